// File: rtl/overcooked_pkg.sv
// Shared game encodings (player state, facing direction, station tiles) for the
// player controller and sprite renderer, plus the pick-up/put-down rule table.
package overcooked_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [3:0] {
    ST_NOTHING       = 4'd0,
    ST_CHOPPING      = 4'd1,
    ST_ONION_WHOLE   = 4'd2,
    ST_ONION_CHOPPED = 4'd3,
    ST_POT_EMPTY     = 4'd4,
    ST_POT_RAW       = 4'd5,
    ST_POT_COOKED    = 4'd6,
    ST_BOWL_EMPTY    = 4'd7,
    ST_BOWL_FULL     = 4'd8,
    ST_EXT_OFF       = 4'd9,
    ST_EXT_ON        = 4'd10
  } pstate_e;

  typedef enum logic [2:0] {
    STN_FLOOR      = 3'd0,
    STN_COUNTER    = 3'd1,
    STN_ONION_BIN  = 3'd2,
    STN_BOARD      = 3'd3,
    STN_STOVE      = 3'd4,
    STN_BOWL_STACK = 3'd5,
    STN_SERVE      = 3'd6,
    STN_EXT_STAND  = 3'd7
  } station_e;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_PENDING = 2'd1,
    FSM_CHOP    = 2'd2
  } fsm_e;

  typedef struct packed {
    logic       hit;
    logic       place;
    logic [3:0] item;
    pstate_e    on_ack;
    logic       serve;
  } rule_t;

  // Takes report item 0; only a place names the item handed to the world.
  function automatic rule_t eval_rule(input pstate_e held, input station_e stn,
                                      input logic [3:0] sitem);
    rule_t r;
    r.hit    = 1'b0;
    r.place  = 1'b0;
    r.item   = 4'd0;
    r.on_ack = held;
    r.serve  = 1'b0;
    if (held == ST_NOTHING) begin
      case (stn)
        STN_ONION_BIN: begin
          r.hit    = 1'b1;
          r.on_ack = ST_ONION_WHOLE;
        end
        STN_BOWL_STACK: begin
          r.hit    = 1'b1;
          r.on_ack = ST_BOWL_EMPTY;
        end
        STN_EXT_STAND: begin
          r.hit    = 1'b1;
          r.on_ack = ST_EXT_OFF;
        end
        STN_COUNTER, STN_BOARD, STN_STOVE: begin
          if (sitem != 4'd0) begin
            r.hit    = 1'b1;
            r.on_ack = pstate_e'(sitem);
          end
        end
        default: ;
      endcase
    end else begin
      r.place  = 1'b1;
      r.item   = held;
      r.on_ack = ST_NOTHING;
      if (stn == STN_COUNTER && sitem == 4'd0) begin
        r.hit = 1'b1;
      end else if (held == ST_ONION_WHOLE && stn == STN_BOARD && sitem == 4'd0) begin
        r.hit = 1'b1;
      end else if (held == ST_ONION_CHOPPED && (stn == STN_COUNTER || stn == STN_STOVE) &&
                   sitem == ST_POT_EMPTY) begin
        r.hit = 1'b1;
      end else if (held == ST_POT_COOKED && stn == STN_COUNTER && sitem == ST_BOWL_EMPTY) begin
        r.hit    = 1'b1;
        r.on_ack = ST_POT_EMPTY;
      end else if (held == ST_BOWL_FULL && stn == STN_SERVE) begin
        r.hit   = 1'b1;
        r.serve = 1'b1;
      end else if ((held == ST_EXT_OFF || held == ST_EXT_ON) && stn == STN_EXT_STAND &&
                   sitem == 4'd0) begin
        r.hit = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/chop_timer.sv
// Frame-tick counter; done_o pulses combinationally on the tick that completes
// FRAMES ticks, after which the count restarts from zero (it never wraps).
module chop_timer #(
  parameter  int unsigned FRAMES = 90,
  localparam int unsigned W      = $clog2(FRAMES + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic done_o
);

  localparam logic [W-1:0] LAST = W'(FRAMES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = tick_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || done_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_action_ctrl.sv
// Player action controller: take/place handshake with the world, chopping and
// extinguisher spray; sprite-facing outputs only change on frame ticks.
module player_action_ctrl
  import overcooked_pkg::*;
#(
  parameter int unsigned CHOP_FRAMES = 90
) (
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic       frame_tick_in,
  input  logic [3:0] dir_in,
  input  logic       action_in,
  input  logic       chop_in,
  input  logic       spray_in,
  input  logic [2:0] station_in,
  input  logic [3:0] station_item_in,
  input  logic       ack_in,
  output logic [1:0] player_direction,
  output logic [3:0] player_state,
  output logic       req_valid_out,
  output logic       req_place_out,
  output logic [3:0] req_item_out,
  output logic       chop_done_out,
  output logic       served_out
);

  fsm_e       fsm_q, fsm_d;
  dir_e       dir_q, dir_d;
  pstate_e    state_q, state_d;
  pstate_e    ack_state_q, ack_state_d;
  dir_e       out_dir_q;
  pstate_e    out_state_q;
  logic       req_valid_q, req_valid_d;
  logic       req_place_q, req_place_d;
  logic [3:0] req_item_q, req_item_d;
  logic       serve_q, serve_d;

  rule_t      rule;
  logic       chop_abort;
  logic       timer_clear;
  logic       timer_done;

  assign rule        = eval_rule(state_q, station_e'(station_in), station_item_in);
  assign chop_abort  = !chop_in || (station_in != STN_BOARD);
  assign timer_clear = (fsm_q != FSM_CHOP) || chop_abort;

  chop_timer #(.FRAMES(CHOP_FRAMES)) u_chop_timer (
    .clk_i   (pixel_clk_in),
    .rst_n_i (rst_n_in),
    .clear_i (timer_clear),
    .tick_i  (frame_tick_in),
    .done_o  (timer_done)
  );

  always_comb begin
    fsm_d       = fsm_q;
    dir_d       = dir_q;
    state_d     = state_q;
    ack_state_d = ack_state_q;
    req_valid_d = req_valid_q;
    req_place_d = req_place_q;
    req_item_d  = req_item_q;
    serve_d     = serve_q;

    if (frame_tick_in && state_q != ST_CHOPPING && $onehot(dir_in)) begin
      if (dir_in[3])      dir_d = DIR_UP;
      else if (dir_in[2]) dir_d = DIR_DOWN;
      else if (dir_in[1]) dir_d = DIR_LEFT;
      else                dir_d = DIR_RIGHT;
    end

    case (fsm_q)
      FSM_IDLE: begin
        if (action_in && rule.hit) begin
          fsm_d       = FSM_PENDING;
          req_valid_d = 1'b1;
          req_place_d = rule.place;
          req_item_d  = rule.item;
          ack_state_d = rule.on_ack;
          serve_d     = rule.serve;
        end else if (chop_in && state_q == ST_NOTHING && station_in == STN_BOARD &&
                     station_item_in == ST_ONION_WHOLE) begin
          fsm_d   = FSM_CHOP;
          state_d = ST_CHOPPING;
        end else if (state_q == ST_EXT_OFF && spray_in) begin
          state_d = ST_EXT_ON;
        end else if (state_q == ST_EXT_ON && !spray_in) begin
          state_d = ST_EXT_OFF;
        end
      end
      FSM_PENDING: begin
        // Everything but ack is ignored here, including an action on the ack cycle.
        if (ack_in) begin
          fsm_d       = FSM_IDLE;
          state_d     = ack_state_q;
          req_valid_d = 1'b0;
          serve_d     = 1'b0;
        end
      end
      FSM_CHOP: begin
        if (chop_abort || timer_done) begin
          fsm_d   = FSM_IDLE;
          state_d = ST_NOTHING;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      fsm_q       <= FSM_IDLE;
      dir_q       <= DIR_DOWN;
      state_q     <= ST_NOTHING;
      ack_state_q <= ST_NOTHING;
      out_dir_q   <= DIR_DOWN;
      out_state_q <= ST_NOTHING;
      req_valid_q <= 1'b0;
      req_place_q <= 1'b0;
      req_item_q  <= 4'd0;
      serve_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      dir_q       <= dir_d;
      state_q     <= state_d;
      ack_state_q <= ack_state_d;
      req_valid_q <= req_valid_d;
      req_place_q <= req_place_d;
      req_item_q  <= req_item_d;
      serve_q     <= serve_d;
      // Copy next-state values so a change made on a tick cycle shows that same frame.
      if (frame_tick_in) begin
        out_dir_q   <= dir_d;
        out_state_q <= state_d;
      end
    end
  end

  assign player_direction = out_dir_q;
  assign player_state     = out_state_q;
  assign req_valid_out    = req_valid_q;
  assign req_place_out    = req_place_q;
  assign req_item_out     = req_item_q;
  assign chop_done_out    = (fsm_q == FSM_CHOP) && timer_done;
  assign served_out       = (fsm_q == FSM_PENDING) && ack_in && serve_q;

endmodule

// File: doc/player_action_ctrl.md
PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 Parameter CHOP_FRAMES, default 90, frames chop_in must be held to finish one chop.
REQ-002 pixel_clk_in  in  1  sole clock.
REQ-003 rst_n_in  in  1  synchronous, active-low reset.
REQ-004 frame_tick_in  in  1  one-cycle pulse per video frame (start of vblank).
REQ-005 dir_in  in  4  button levels {up,down,left,right} = bits [3:0].
REQ-006 action_in  in  1  one-cycle pulse: pick up / put down / interact.
REQ-007 chop_in, spray_in  in  1 each  button levels.
REQ-008 station_in  in  3  faced tile: 0 FLOOR, 1 COUNTER, 2 ONION_BIN, 3 BOARD, 4 STOVE, 5 BOWL_STACK, 6 SERVE, 7 EXT_STAND.
REQ-009 station_item_in  in  4  item on faced tile, player-state encoding (0 = empty).
REQ-010 ack_in  in  1  world acknowledges the pending take/place request.
REQ-011 player_direction  out  2  LEFT 0, RIGHT 1, UP 2, DOWN 3; drives the sprite renderer.
REQ-012 player_state  out  4  NOTHING 0, CHOPPING 1, ONION_WHOLE 2, ONION_CHOPPED 3, POT_EMPTY 4, POT_RAW 5, POT_COOKED 6, BOWL_EMPTY 7, BOWL_FULL 8, EXT_OFF 9, EXT_ON 10.
REQ-013 req_valid_out  out  1, req_place_out  out  1 (1 place, 0 take), req_item_out  out  4 (item placed).
REQ-014 chop_done_out, served_out  out  1 each  one-cycle pulses.

Function
REQ-015 Internal working direction/state registers update every cycle; player_direction/player_state copy them only on cycles with frame_tick_in=1, so no mid-frame sprite change.
REQ-016 On frame_tick_in with exactly one dir_in bit set and working state != CHOPPING, working direction takes that value; zero or several bits set leaves it unchanged.
REQ-017 FSM states: IDLE, PENDING, CHOP.
REQ-018 IDLE, action_in=1: evaluate the rule table (REQ-019); a matching rule asserts req_valid_out with req_place_out/req_item_out next cycle and enters PENDING; no match leaves everything unchanged.
REQ-019 Rules (held, station, station item -> request, held on ack): NOTHING,ONION_BIN,any -> take, ONION_WHOLE; NOTHING,BOWL_STACK,any -> take, BOWL_EMPTY; NOTHING,EXT_STAND,any -> take, EXT_OFF; NOTHING,{COUNTER,BOARD,STOVE},item!=0 -> take, item; X!=0,COUNTER,0 -> place X, NOTHING; ONION_WHOLE,BOARD,0 -> place, NOTHING; ONION_CHOPPED,{COUNTER,STOVE},POT_EMPTY -> place, NOTHING; POT_COOKED,COUNTER,BOWL_EMPTY -> place, POT_EMPTY; BOWL_FULL,SERVE,any -> place, NOTHING; {EXT_OFF,EXT_ON},EXT_STAND,0 -> place, NOTHING.
REQ-020 Request outputs held stable in PENDING until ack_in=1; on ack cycle working state takes its on-ack value, req_valid_out drops next cycle, FSM returns IDLE.
REQ-021 served_out pulses on the ack cycle of a SERVE place.
REQ-022 action_in, chop_in, spray_in ignored in PENDING; action_in coincident with ack_in ignored.
REQ-023 ack_in outside PENDING ignored.
REQ-024 IDLE, held NOTHING, station BOARD, item ONION_WHOLE, chop_in=1 -> CHOP, working state CHOPPING, frame counter cleared.
REQ-025 CHOP: counter increments on each frame_tick_in; when it reaches CHOP_FRAMES, chop_done_out pulses that cycle, counter clears, FSM -> IDLE, state NOTHING.
REQ-026 CHOP: chop_in=0 or station_in!=BOARD -> IDLE, state NOTHING, counter cleared, no chop_done_out.
REQ-027 Counter width $clog2(CHOP_FRAMES+1); never wraps.
REQ-028 IDLE, working state EXT_OFF with spray_in=1 -> EXT_ON; EXT_ON with spray_in=0 -> EXT_OFF; action_in honoured in both.

Reset
REQ-029 rst_n_in=0 at a clock edge: FSM IDLE, working and output direction DOWN, state NOTHING, counter 0, all request/pulse outputs 0, regardless of pending request; takes effect without waiting for frame_tick_in.

Structure
REQ-030 Player-state, direction and station encodings are typedef enums in shared package overcooked_pkg, also used by the sprite renderer.
REQ-031 Frame counter is sub-module chop_timer (clear, tick, done), reusable for stove cook time.

Verification
REQ-032 Reset, dir_in=0010 then tick -> outputs DOWN/NOTHING after reset, LEFT only at the tick cycle, unchanged between ticks.
REQ-033 NOTHING at ONION_BIN, action, ack 3 cycles later -> req take held 3 cycles, player_state ONION_WHOLE at next tick.
REQ-034 CHOP_FRAMES=4, chop held 4 ticks -> one chop_done_out on 4th tick, state NOTHING; release after 2 ticks -> no pulse.
REQ-035 BOWL_FULL at SERVE, action, ack coincident with second action -> one served_out, state NOTHING, second action ignored.
REQ-036 PENDING then rst_n_in=0 -> req_valid_out 0 next cycle, state NOTHING, later ack_in ignored.
REQ-037 EXT_OFF, spray 1 then 0 across ticks -> EXT_ON then EXT_OFF; dir_in=1100 -> direction unchanged.
